// File: rtl/counter_updown.sv
// Up/down counter over [LOWER, UPPER] with runtime direction/step, clamped load, wrap or saturate.
// Latency: one cycle from sampled inputs to value_o/event_o; at_upper_o/at_lower_o decode value_o directly.
// Backpressure: none; ena_i may stay high indefinitely for one step per cycle.
//
// Ports: clk_i, rst_i (sync, active-high), ena_i, dir_i (1=up), step_i[STEP_WIDTH],
//        load_i, load_value_i[WIDTH], value_o[WIDTH], at_upper_o, at_lower_o, event_o.
// Build option: define COUNTER_UPDOWN_LOAD_EN to include the load path; otherwise
//        load_i/load_value_i are accepted but ignored and priority is rst_i > ena_i.
module counter_updown #(
    parameter int LOWER      = 0,
    parameter int UPPER      = 255,
    parameter int WRAPAROUND = 0,
    parameter int INIT_VALUE = 0,
    parameter int STEP_WIDTH = 1,
    localparam int WIDTH     = (UPPER < 2) ? 1 : $clog2(UPPER + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ena_i,
    input  logic                  dir_i,
    input  logic [STEP_WIDTH-1:0] step_i,
    input  logic                  load_i,
    input  logic [WIDTH-1:0]      load_value_i,
    output logic [WIDTH-1:0]      value_o,
    output logic                  at_upper_o,
    output logic                  at_lower_o,
    output logic                  event_o
);

    // Arithmetic is wide enough that count + step + range never truncates.
    localparam int AW = WIDTH + STEP_WIDTH + 1;

    localparam logic [AW-1:0]    LOWER_A = AW'(LOWER);
    localparam logic [AW-1:0]    UPPER_A = AW'(UPPER);
    localparam logic [AW-1:0]    RANGE_A = AW'(UPPER - LOWER + 1);
    localparam logic [WIDTH-1:0] LOWER_W = WIDTH'(LOWER);
    localparam logic [WIDTH-1:0] UPPER_W = WIDTH'(UPPER);

    // Declaration initialiser gives the power-up value; reset goes to LOWER instead.
    logic [WIDTH-1:0] value_q = WIDTH'(INIT_VALUE);
    logic [WIDTH-1:0] value_d;
    logic             event_q;
    logic             event_d;

    logic [AW-1:0] cnt_a;
    logic [AW-1:0] step_a;
    logic [AW-1:0] sum_a;
    logic          up_over;
    logic          dn_under;

    assign cnt_a  = AW'(value_q);
    assign step_a = AW'(step_i);
    assign sum_a  = cnt_a + step_a;

    assign up_over  = (sum_a > UPPER_A);
    // count - step < LOWER, rearranged so nothing goes negative.
    assign dn_under = (cnt_a < (LOWER_A + step_a));

`ifdef COUNTER_UPDOWN_LOAD_EN
    logic [AW-1:0]    load_a;
    logic [WIDTH-1:0] load_clamped;

    assign load_a = AW'(load_value_i);

    // "below LOWER" written as +1 <= LOWER so it stays a real compare when LOWER is 0.
    always_comb begin
        load_clamped = load_value_i;
        if ((load_a + AW'(1)) <= LOWER_A) begin
            load_clamped = LOWER_W;
        end else if (load_a > UPPER_A) begin
            load_clamped = UPPER_W;
        end
    end
`else
    logic unused_load;
    assign unused_load = ^{load_i, load_value_i};
`endif

    always_comb begin
        value_d = value_q;
        event_d = 1'b0;
        if (ena_i) begin
            if (dir_i) begin
                if (up_over) begin
                    event_d = 1'b1;
                    value_d = (WRAPAROUND != 0) ? WIDTH'(sum_a - RANGE_A) : UPPER_W;
                end else begin
                    value_d = WIDTH'(sum_a);
                end
            end else begin
                if (dn_under) begin
                    event_d = 1'b1;
                    value_d = (WRAPAROUND != 0) ? WIDTH'(cnt_a + RANGE_A - step_a) : LOWER_W;
                end else begin
                    value_d = WIDTH'(cnt_a - step_a);
                end
            end
        end
`ifdef COUNTER_UPDOWN_LOAD_EN
        // Load overrides any step taken in the same cycle.
        if (load_i) begin
            value_d = load_clamped;
            event_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            value_q <= LOWER_W;
            event_q <= 1'b0;
        end else begin
            value_q <= value_d;
            event_q <= event_d;
        end
    end

    assign value_o    = value_q;
    assign event_o    = event_q;
    assign at_upper_o = (value_q == UPPER_W);
    assign at_lower_o = (value_q == LOWER_W);

endmodule

// File: tb/tb_counter_updown.sv
// Bench for counter_updown: a wrapping and a saturating instance (LOWER=2, UPPER=9, STEP_WIDTH=4)
// share one stimulus stream; expected results are queued at drive time and compared after the edge.
// Directed test-plan sequences first, then a random phase checked against the reference model.
module tb_counter_updown;

    localparam int LO = 2;
    localparam int HI = 9;
    localparam int RR = HI - LO + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ena = 1'b0;
    logic       dir = 1'b0;
    logic [3:0] step = '0;
    logic       load = 1'b0;
    logic [3:0] load_value = '0;

    logic [3:0] val_w, val_s;
    logic       up_w, lo_w, ev_w;
    logic       up_s, lo_s, ev_s;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int vw;
        bit ew;
        int vs;
        bit es;
    } exp_t;

    exp_t sb[$];
    int   cw = 5;
    int   cs = 5;

    always #5 clk = ~clk;

    counter_updown #(
        .LOWER(LO), .UPPER(HI), .WRAPAROUND(1), .INIT_VALUE(5), .STEP_WIDTH(4)
    ) u_wrap (
        .clk_i(clk), .rst_i(rst), .ena_i(ena), .dir_i(dir), .step_i(step),
        .load_i(load), .load_value_i(load_value),
        .value_o(val_w), .at_upper_o(up_w), .at_lower_o(lo_w), .event_o(ev_w)
    );

    counter_updown #(
        .LOWER(LO), .UPPER(HI), .WRAPAROUND(0), .INIT_VALUE(5), .STEP_WIDTH(4)
    ) u_sat (
        .clk_i(clk), .rst_i(rst), .ena_i(ena), .dir_i(dir), .step_i(step),
        .load_i(load), .load_value_i(load_value),
        .value_o(val_s), .at_upper_o(up_s), .at_lower_o(lo_s), .event_o(ev_s)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference behaviour in plain integer arithmetic.
    function automatic int model(input int c, input bit wrap, input bit r, input bit e,
                                 input bit d, input int st, input bit ld, input int lv,
                                 output bit ev);
        int s;
        ev = 1'b0;
        if (r) return LO;
`ifdef COUNTER_UPDOWN_LOAD_EN
        if (ld) return (lv < LO) ? LO : ((lv > HI) ? HI : lv);
`endif
        if (!e) return c;
        if (d) begin
            s = c + st;
            if (s <= HI) return s;
            ev = 1'b1;
            return wrap ? s - RR : HI;
        end
        s = c - st;
        if (s >= LO) return s;
        ev = 1'b1;
        return wrap ? s + RR : LO;
    endfunction

    task automatic cyc(input bit r, input bit e, input bit d, input int st,
                       input bit ld, input int lv);
        exp_t x;
        @(negedge clk);
        rst        = r;
        ena        = e;
        dir        = d;
        step       = st[3:0];
        load       = ld;
        load_value = lv[3:0];
        cw   = model(cw, 1'b1, r, e, d, st, ld, lv, x.ew);
        x.vw = cw;
        cs   = model(cs, 1'b0, r, e, d, st, ld, lv, x.es);
        x.vs = cs;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check("w_value", val_w, x.vw);
        check("w_event", ev_w, x.ew);
        check("w_at_upper", up_w, (x.vw == HI));
        check("w_at_lower", lo_w, (x.vw == LO));
        check("s_value", val_s, x.vs);
        check("s_event", ev_s, x.es);
        check("s_at_upper", up_s, (x.vs == HI));
        check("s_at_lower", lo_s, (x.vs == LO));
    endtask

    initial begin
        #1;
        // Power-up value before any reset.
        check("powerup_value_w", val_w, 5);
        check("powerup_value_s", val_s, 5);
        check("powerup_event", ev_w, 0);

        // Reset, then up by 3 four times: wrap 2,5,8,3,6; saturate 2,5,8,9,9.
        cyc(1, 0, 1, 0, 0, 0);
        check("reset_value", val_w, 2);
        check("reset_at_lower", lo_w, 1);
        check("reset_at_upper", up_w, 0);
        cyc(0, 1, 1, 3, 0, 0);
        cyc(0, 1, 1, 3, 0, 0);
        check("plan_up_8", val_w, 8);
        cyc(0, 1, 1, 3, 0, 0);
        check("plan_wrap_3", val_w, 3);
        check("plan_wrap_event", ev_w, 1);
        check("plan_sat_9", val_s, 9);
        check("plan_sat_event", ev_s, 1);
        cyc(0, 1, 1, 3, 0, 0);
        check("plan_wrap_6", val_w, 6);
        check("plan_wrap_event_clear", ev_w, 0);
        check("plan_sat_sticky", ev_s, 1);
        check("plan_sat_hold", val_s, 9);

        // Down: wrap 6->3, then 3-4 wraps to 7, then 7-5 lands on LOWER.
        cyc(0, 1, 0, 3, 0, 0);
        cyc(0, 1, 0, 4, 0, 0);
        check("plan_down_wrap_7", val_w, 7);
        check("plan_down_wrap_event", ev_w, 1);
        cyc(0, 1, 0, 5, 0, 0);
        check("plan_down_to_lower", val_w, 2);
        check("plan_down_lower_flag", lo_w, 1);
        check("plan_down_no_event", ev_w, 0);

        // Edge steps: step 0 holds, step R wraps back to the same value.
        cyc(0, 1, 1, 0, 0, 0);
        check("plan_step0_event", ev_w, 0);
        cyc(0, 1, 1, RR, 0, 0);
        check("plan_stepR_value", val_w, 2);
        check("plan_stepR_event", ev_w, 1);
        cyc(0, 0, 1, 3, 0, 0);

        // Load clamp and priority (ignored when the load path is not built).
        cyc(0, 1, 1, 1, 1, 12);
        cyc(0, 0, 1, 1, 1, 0);
        cyc(1, 1, 1, 1, 1, 7);
        check("plan_rst_over_load", val_w, 2);
        cyc(0, 1, 1, 2, 0, 0);
        cyc(0, 1, 1, 1, 1, 7);
`ifndef COUNTER_UPDOWN_LOAD_EN
        check("plan_load_ignored", val_w, 5);
`else
        check("plan_load_wins", val_w, 7);
`endif

        // Random phase against the model.
        for (int i = 0; i < 300; i++) begin
            cyc(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
                $urandom_range(0, 1), $urandom_range(0, RR),
                ($urandom_range(0, 7) == 0), $urandom_range(0, 15));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
